// File: rtl/mem_region_decoder_if.sv
// mem_region_decoder_if: region bounds, core request, IM/DM forward and fault record signals
interface mem_region_decoder_if #(
  parameter int ADDR_W = 64,
  parameter int FCNT_W = 16
);
  logic [ADDR_W-1:0] im_bottom;
  logic [ADDR_W-1:0] im_top;
  logic [ADDR_W-1:0] dm_bottom;
  logic [ADDR_W-1:0] dm_top;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_fetch;
  logic              req_write;
  logic              im_valid;
  logic              im_ready;
  logic [ADDR_W-1:0] im_addr;
  logic              dm_valid;
  logic              dm_ready;
  logic [ADDR_W-1:0] dm_addr;
  logic              dm_write;
  logic              fault_valid;
  logic [1:0]        fault_code;
  logic [ADDR_W-1:0] fault_addr;
  logic [FCNT_W-1:0] fault_count;
  modport master (
    output im_bottom, im_top, dm_bottom, dm_top,
    output req_valid, req_addr, req_fetch, req_write, im_ready, dm_ready,
    input  req_ready, im_valid, im_addr, dm_valid, dm_addr, dm_write,
    input  fault_valid, fault_code, fault_addr, fault_count
  );
  modport slave (
    input  im_bottom, im_top, dm_bottom, dm_top,
    input  req_valid, req_addr, req_fetch, req_write, im_ready, dm_ready,
    output req_ready, im_valid, im_addr, dm_valid, dm_addr, dm_write,
    output fault_valid, fault_code, fault_addr, fault_count
  );
endinterface

// File: rtl/mem_region_decoder.sv
// mem_region_decoder: range-checks core requests and forwards them as region offsets to IM/DM (optional alignment check: MEM_REGION_ALIGN_CHECK_EN)
module mem_region_decoder #(
  parameter int ADDR_W = 64,
  parameter int FCNT_W = 16
) (
  input logic                 clk,
  input logic                 reset,
  mem_region_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE_IM, ISSUE_DM, FAULT} state_t;
  state_t     state;
  logic       in_im;
  logic       in_dm;
  logic       misaligned;
  logic [1:0] code;
  // classify the presented request; code 0 means it may be forwarded
  always_comb begin
    in_im = bus.req_addr >= bus.im_bottom && bus.req_addr <= bus.im_top;
    in_dm = bus.req_addr >= bus.dm_bottom && bus.req_addr <= bus.dm_top;
`ifdef MEM_REGION_ALIGN_CHECK_EN
    misaligned = bus.req_fetch ? |bus.req_addr[1:0] : |bus.req_addr[2:0];
`else
    misaligned = 1'b0;
`endif
    code = (bus.req_fetch && bus.req_write) ? 2'd2 :
           misaligned                       ? 2'd3 :
           (bus.req_fetch ? in_im : in_dm)  ? 2'd0 : 2'd1;
  end
  // request FSM with registered forward, ready and fault outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bus.req_ready   <= 1'b1;
      bus.im_valid    <= 1'b0;
      bus.im_addr     <= '0;
      bus.dm_valid    <= 1'b0;
      bus.dm_addr     <= '0;
      bus.dm_write    <= 1'b0;
      bus.fault_valid <= 1'b0;
      bus.fault_code  <= 2'd0;
      bus.fault_addr  <= '0;
      bus.fault_count <= '0;
    end else begin
      bus.fault_valid <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          bus.req_ready <= 1'b0;
          if (code != 2'd0) begin
            state           <= FAULT;
            bus.fault_valid <= 1'b1;
            bus.fault_code  <= code;
            bus.fault_addr  <= bus.req_addr;
            bus.fault_count <= bus.fault_count + {{(FCNT_W-1){1'b0}}, ~&bus.fault_count};
          end else if (bus.req_fetch) begin
            state        <= ISSUE_IM;
            bus.im_valid <= 1'b1;
            bus.im_addr  <= bus.req_addr - bus.im_bottom;
          end else begin
            state        <= ISSUE_DM;
            bus.dm_valid <= 1'b1;
            bus.dm_addr  <= bus.req_addr - bus.dm_bottom;
            bus.dm_write <= bus.req_write;
          end
        end
        ISSUE_IM: if (bus.im_ready) begin
          state         <= IDLE;
          bus.im_valid  <= 1'b0;
          bus.req_ready <= 1'b1;
        end
        ISSUE_DM: if (bus.dm_ready) begin
          state         <= IDLE;
          bus.dm_valid  <= 1'b0;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_region_decoder.sv
// tb_mem_region_decoder: vector table, corner sequences and randomized traffic against a reference model
module tb_mem_region_decoder;
  localparam int AW = 64;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [63:0] IB = 64'h0;
  localparam logic [63:0] IT = 64'h7_FFFF_FFFF;
  localparam logic [63:0] DB = 64'h8_0000_0000;
  localparam logic [63:0] DT = 64'hF_FFFF_FFFF;
  typedef struct {
    logic [63:0] addr;
    logic        fetch;
    logic        write;
    logic [63:0] ib, it, db, dt;
    logic [1:0]  code;
    logic [63:0] off;
    int          dly;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0;
  vec_t tbl[14];
  mem_region_decoder_if #(.ADDR_W(AW), .FCNT_W(CW)) bus ();
  mem_region_decoder #(.ADDR_W(AW), .FCNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction
  function automatic logic [1:0] ref_code(logic [63:0] a, logic f, logic w,
                                          logic [63:0] ib, it, db, dt);
    if (f && w) return 2'd2;
`ifdef MEM_REGION_ALIGN_CHECK_EN
    if ((f ? a % 4 : a % 8) != 0) return 2'd3;
`endif
    if (f) return (a >= ib && a <= it) ? 2'd0 : 2'd1;
    return (a >= db && a <= dt) ? 2'd0 : 2'd1;
  endfunction
  task automatic set_bounds(input logic [63:0] ib, it, db, dt);
    bus.im_bottom = ib;
    bus.im_top    = it;
    bus.dm_bottom = db;
    bus.dm_top    = dt;
  endtask
  task automatic do_req(input logic [63:0] a, input logic f, input logic w,
                        input logic [1:0] ec, input logic [63:0] eo, input int dly);
    int t = 0;
    while (!bus.req_ready && t < 10) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_wait", {63'd0, bus.req_ready}, 64'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_fetch = f;
    bus.req_write = w;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("req_ready_busy", {63'd0, bus.req_ready}, 64'd0);
    if (ec == 2'd0) begin
      chk("fwd_valid", {63'd0, f ? bus.im_valid : bus.dm_valid}, 64'd1);
      chk("other_valid", {63'd0, f ? bus.dm_valid : bus.im_valid}, 64'd0);
      chk("fwd_addr", f ? bus.im_addr : bus.dm_addr, eo);
      if (!f) chk("dm_write", {63'd0, bus.dm_write}, {63'd0, w});
      chk("no_fault", {63'd0, bus.fault_valid}, 64'd0);
      for (int i = 0; i < dly; i++) begin
        @(posedge clk); #1;
        chk("hold_valid", {63'd0, f ? bus.im_valid : bus.dm_valid}, 64'd1);
        chk("hold_addr", f ? bus.im_addr : bus.dm_addr, eo);
        chk("hold_ready", {63'd0, bus.req_ready}, 64'd0);
      end
      if (f) bus.im_ready = 1'b1; else bus.dm_ready = 1'b1;
      @(posedge clk); #1;
      bus.im_ready = 1'b0;
      bus.dm_ready = 1'b0;
      chk("done_valid", {63'd0, f ? bus.im_valid : bus.dm_valid}, 64'd0);
      chk("done_ready", {63'd0, bus.req_ready}, 64'd1);
    end else begin
      exp_cnt = exp_cnt < CMAX ? exp_cnt + 1 : exp_cnt;
      chk("fault_valid", {63'd0, bus.fault_valid}, 64'd1);
      chk("fault_code", {62'd0, bus.fault_code}, {62'd0, ec});
      chk("fault_addr", bus.fault_addr, a);
      chk("fault_count", {{(64-CW){1'b0}}, bus.fault_count}, 64'(exp_cnt));
      chk("fault_no_fwd", {62'd0, bus.im_valid, bus.dm_valid}, 64'd0);
      @(posedge clk); #1;
      chk("fault_pulse_end", {63'd0, bus.fault_valid}, 64'd0);
      chk("fault_ready", {63'd0, bus.req_ready}, 64'd1);
      chk("fault_sticky", bus.fault_addr, a);
    end
  endtask
  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [63:0] a, ib, it, db, dt, bases[5];
    logic        f, w;
    logic [1:0]  ec;
    tbl[0]  = '{64'h100, 1'b1, 1'b0, IB, IT, DB, DT, 2'd0, 64'h100, 3};
    tbl[1]  = '{64'h8_0000_0040, 1'b0, 1'b1, IB, IT, DB, DT, 2'd0, 64'h40, 0};
    tbl[2]  = '{64'h7_FFFF_FFFC, 1'b1, 1'b0, IB, IT, DB, DT, 2'd0, 64'h7_FFFF_FFFC, 1};
    tbl[3]  = '{64'hF_FFFF_FFF8, 1'b0, 1'b0, IB, IT, DB, DT, 2'd0, 64'h7_FFFF_FFF8, 0};
    tbl[4]  = '{64'h10_0000_0000, 1'b0, 1'b0, IB, IT, DB, DT, 2'd1, 64'h0, 0};
    tbl[5]  = '{64'h0, 1'b1, 1'b1, IB, IT, DB, DT, 2'd2, 64'h0, 0};
`ifdef MEM_REGION_ALIGN_CHECK_EN
    tbl[6]  = '{64'h102, 1'b1, 1'b0, IB, IT, DB, DT, 2'd3, 64'h0, 0};
    tbl[13] = '{64'h8_0000_0044, 1'b0, 1'b0, IB, IT, DB, DT, 2'd3, 64'h0, 0};
`else
    tbl[6]  = '{64'h102, 1'b1, 1'b0, IB, IT, DB, DT, 2'd0, 64'h102, 0};
    tbl[13] = '{64'h8_0000_0044, 1'b0, 1'b0, IB, IT, DB, DT, 2'd0, 64'h44, 2};
`endif
    tbl[7]  = '{64'h8_0000_0000, 1'b1, 1'b0, IB, IT, DB, DT, 2'd1, 64'h0, 0};
    tbl[8]  = '{64'h7_FFFF_FFF8, 1'b0, 1'b1, IB, IT, DB, DT, 2'd1, 64'h0, 0};
    tbl[9]  = '{64'h8_0000_0000, 1'b0, 1'b0, IB, IT, DB, DT, 2'd0, 64'h0, 0};
    tbl[10] = '{64'h1000, 1'b1, 1'b0, 64'h1000, 64'hFFF, DB, DT, 2'd1, 64'h0, 0};
    tbl[11] = '{64'h2000, 1'b0, 1'b1, IB, IT, 64'h2000, 64'h2000, 2'd0, 64'h0, 1};
    tbl[12] = '{64'h10_0000_0000, 1'b1, 1'b1, IB, IT, DB, DT, 2'd2, 64'h0, 0};
    set_bounds(IB, IT, DB, DT);
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_fetch = 1'b0;
    bus.req_write = 1'b0;
    bus.im_ready  = 1'b0;
    bus.dm_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_valids", {61'd0, bus.im_valid, bus.dm_valid, bus.fault_valid}, 64'd0);
    chk("rst_im_addr", bus.im_addr, 64'd0);
    chk("rst_dm_addr", bus.dm_addr, 64'd0);
    chk("rst_dm_write", {63'd0, bus.dm_write}, 64'd0);
    chk("rst_fault_code", {62'd0, bus.fault_code}, 64'd0);
    chk("rst_fault_addr", bus.fault_addr, 64'd0);
    chk("rst_fault_count", {{(64-CW){1'b0}}, bus.fault_count}, 64'd0);
    reset = 1'b0;
    bus.im_ready = 1'b1;
    bus.dm_ready = 1'b1;
    @(posedge clk); #1;
    bus.im_ready = 1'b0;
    bus.dm_ready = 1'b0;
    chk("idle_ready_ignored", {61'd0, bus.im_valid, bus.dm_valid, bus.req_ready}, 64'd1);
    for (int i = 0; i < 14; i++) begin
      set_bounds(tbl[i].ib, tbl[i].it, tbl[i].db, tbl[i].dt);
      do_req(tbl[i].addr, tbl[i].fetch, tbl[i].write, tbl[i].code, tbl[i].off, tbl[i].dly);
    end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        ib = IB; it = IT; db = DB; dt = DT;
      end else begin
        ib = {$urandom(), $urandom()}; it = {$urandom(), $urandom()};
        db = {$urandom(), $urandom()}; dt = {$urandom(), $urandom()};
      end
      set_bounds(ib, it, db, dt);
      bases = '{ib, it, db, dt, {$urandom(), $urandom()}};
      a = bases[$urandom_range(0, 4)] + 64'($urandom_range(0, 16)) - 64'd8;
      f = 1'($urandom_range(0, 1));
      w = $urandom_range(0, 5) == 0 ? f : 1'($urandom_range(0, 1));
      ec = ref_code(a, f, w, ib, it, db, dt);
      do_req(a, f, w, ec, a - (f ? ib : db), $urandom_range(0, 3));
    end
    set_bounds(IB, IT, DB, DT);
    for (int i = 0; i < CMAX + 3; i++) do_req({$urandom(), $urandom()}, 1'b1, 1'b1, 2'd2, 64'd0, 0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 64'h8_0000_0080;
    bus.req_fetch = 1'b0;
    bus.req_write = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("pre_rst_dm_valid", {63'd0, bus.dm_valid}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = 0;
    chk("mid_rst_dm_valid", {63'd0, bus.dm_valid}, 64'd0);
    chk("mid_rst_count", {{(64-CW){1'b0}}, bus.fault_count}, 64'd0);
    chk("mid_rst_fault_addr", bus.fault_addr, 64'd0);
    chk("mid_rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    do_req(64'h10_0000_0000, 1'b0, 1'b0, 2'd1, 64'd0, 0);
    do_req(64'h200, 1'b1, 1'b0, 2'd0, 64'h200, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_region_decoder.md
Name: mem_region_decoder

Overview:
- Consumer side of the memory-map controller's region outputs (IM/DM bottom/top bounds plus reset).
- Accepts one memory access request at a time from the core over a valid/ready handshake.
- Checks the request address against the instruction or data region bounds and forwards it, rebased to a region offset, to the IM or DM port.
- Out-of-bounds or illegal accesses produce a fault pulse, a sticky fault record and a saturating fault count instead of being forwarded.

Parameters:
- ADDR_W, 64, width of request address, region bounds and forwarded offset.
- FCNT_W, 16, width of saturating fault counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- im_bottom  in  ADDR_W  first instruction-memory address, inclusive.
- im_top  in  ADDR_W  last instruction-memory address, inclusive.
- dm_bottom  in  ADDR_W  first data-memory address, inclusive.
- dm_top  in  ADDR_W  last data-memory address, inclusive.
- req_valid  in  1  request present.
- req_ready  out  1  decoder can accept a request.
- req_addr  in  ADDR_W  absolute request address.
- req_fetch  in  1  1 = instruction fetch, 0 = data access.
- req_write  in  1  1 = write, 0 = read.
- im_valid  out  1  forwarded fetch valid.
- im_ready  in  1  IM accepts fetch.
- im_addr  out  ADDR_W  req_addr - im_bottom.
- dm_valid  out  1  forwarded data access valid.
- dm_ready  in  1  DM accepts access.
- dm_addr  out  ADDR_W  req_addr - dm_bottom.
- dm_write  out  1  forwarded write flag.
- fault_valid  out  1  one-cycle fault pulse.
- fault_code  out  2  1 = out of range, 2 = write on fetch, 3 = misaligned.
- fault_addr  out  ADDR_W  address of the most recent fault (sticky).
- fault_count  out  FCNT_W  saturating count of faults.

Behaviour:
- Reset values: all outputs 0, except req_ready = 1. State returns to IDLE.
- A request is accepted when req_valid and req_ready are both high on the same edge.
- Bounds are sampled combinationally in the acceptance cycle only.
- States: IDLE, ISSUE_IM, ISSUE_DM, FAULT.
- req_ready = 1 only in IDLE. Throughput is at most 1 request per 2 cycles.
- IDLE, accept with fault-check priority:
  - req_fetch && req_write -> FAULT, code 2.
  - [ALIGN_CHECK_EN] misaligned -> FAULT, code 3.
  - req_fetch && im_bottom <= addr <= im_top -> ISSUE_IM.
  - !req_fetch && dm_bottom <= addr <= dm_top -> ISSUE_DM.
  - Otherwise -> FAULT, code 1.
- Comparisons are unsigned and inclusive at both ends.
- If bottom > top, that region is empty and every access to it faults with code 1.
- Offset subtraction is ADDR_W-bit modulo; no wrap is possible because the address is already range-checked.
- ISSUE_IM / ISSUE_DM:
  - *_valid, *_addr and dm_write are registered; valid rises the cycle after acceptance, so latency is 1.
  - *_addr and dm_write are held stable while *_valid is high.
  - Hold until *_ready is high on an edge, then clear *_valid and go to IDLE.
  - im_valid and dm_valid are never high simultaneously.
- FAULT:
  - fault_valid is high for exactly one cycle (the cycle after acceptance); fault_code is valid with it.
  - fault_addr and fault_code are updated on entry and hold until the next fault.
  - fault_count increments by 1 and saturates at all-ones.
  - Returns to IDLE on the next edge.
- Reset asserted mid-transaction drops any pending forward (*_valid cleared next edge) and clears the counter and fault record.
- *_ready while *_valid is low is ignored.

Optional Feature:
- Macro: MEM_REGION_ALIGN_CHECK_EN.
- Defined:
  - Fetches require addr[1:0] == 0.
  - Data accesses require addr[2:0] == 0.
  - Violations fault with code 3, checked after code 2 and before the range check.
- Undefined: no alignment check; code 3 is never produced.

Test Plan:
- Bounds im 0x0–0x7_FFFF_FFFF, dm 0x8_0000_0000–0xF_FFFF_FFFF; fetch addr 0x100 -> next cycle im_valid=1, im_addr=0x100; im_ready held low 3 cycles -> im_valid and im_addr stable, req_ready=0 throughout.
- Data write addr 0x8_0000_0040 -> dm_valid=1, dm_addr=0x40, dm_write=1; dm_ready=1 -> IDLE, req_ready=1 the following cycle.
- Inclusive boundaries: fetch 0x7_FFFF_FFFC and data 0xF_FFFF_FFF8 forward. Data read 0x10_0000_0000 -> fault_valid pulse, code 1, fault_addr=0x10_0000_0000, fault_count=1.
- Fetch with req_write=1 at 0x0 -> code 2, no im_valid. Preload fault_count=0xFFFF, then fault again -> count stays 0xFFFF.
- Reset asserted while dm_valid=1 awaiting dm_ready -> dm_valid=0, fault_count=0, req_ready=1 after the edge.
- With MEM_REGION_ALIGN_CHECK_EN: fetch 0x102 -> code 3. Without the macro: same fetch forwards with im_addr=0x102.
